// File: rtl/sseg_pkg.sv
// Shared definitions for the 7-segment readback path: segment patterns,
// digit kind encodings, monitor FSM states and the decoded digit record.
package sseg_pkg;

    // Active-low segment patterns, bit6=g .. bit0=a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_NEG   = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] KIND_BLANK   = 2'b00;
    localparam logic [1:0] KIND_HEX     = 2'b01;
    localparam logic [1:0] KIND_NEG     = 2'b10;
    localparam logic [1:0] KIND_INVALID = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SETTLE = 2'b01;
    localparam logic [1:0] ST_HELD   = 2'b10;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] value;
    } digit_t;

endpackage

// File: rtl/sseg_pattern_lut.sv
// Combinational map from a 7-segment pattern to its {kind, value} record.
module sseg_pattern_lut
    import sseg_pkg::*;
(
    input  logic [6:0] pattern,
    output digit_t     digit
);

    // Pattern decode; anything outside the table is reported as invalid
    always_comb begin
        digit = '{kind: KIND_INVALID, value: 4'h0};
        case (pattern)
            SEG_0:     digit = '{kind: KIND_HEX, value: 4'h0};
            SEG_1:     digit = '{kind: KIND_HEX, value: 4'h1};
            SEG_2:     digit = '{kind: KIND_HEX, value: 4'h2};
            SEG_3:     digit = '{kind: KIND_HEX, value: 4'h3};
            SEG_4:     digit = '{kind: KIND_HEX, value: 4'h4};
            SEG_5:     digit = '{kind: KIND_HEX, value: 4'h5};
            SEG_6:     digit = '{kind: KIND_HEX, value: 4'h6};
            SEG_7:     digit = '{kind: KIND_HEX, value: 4'h7};
            SEG_8:     digit = '{kind: KIND_HEX, value: 4'h8};
            SEG_9:     digit = '{kind: KIND_HEX, value: 4'h9};
            SEG_A:     digit = '{kind: KIND_HEX, value: 4'hA};
            SEG_B:     digit = '{kind: KIND_HEX, value: 4'hB};
            SEG_C:     digit = '{kind: KIND_HEX, value: 4'hC};
            SEG_D:     digit = '{kind: KIND_HEX, value: 4'hD};
            SEG_E:     digit = '{kind: KIND_HEX, value: 4'hE};
            SEG_F:     digit = '{kind: KIND_HEX, value: 4'hF};
            SEG_NEG:   digit = '{kind: KIND_NEG, value: 4'h0};
            SEG_BLANK: digit = '{kind: KIND_BLANK, value: 4'h0};
            default:   digit = '{kind: KIND_INVALID, value: 4'h0};
        endcase
    end

endmodule

// File: rtl/sseg_decoder.sv
// Readback monitor for a multiplexed 7-segment bus: debounces each scanned
// position and commits the decoded digit once it has been stable long enough.
module sseg_decoder
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              segs,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digit_val,
    output logic [2*NUM_DIGITS-1:0] digit_kind,
    output logic                    update,
    output logic [2:0]              update_idx,
    output logic                    anode_err
);

    logic [6:0]              segs_r;
    logic [NUM_DIGITS-1:0]   an_r;
    logic [1:0]              state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [2:0]              pos_r;
    logic [6:0]              pat_r;
    logic [4*NUM_DIGITS-1:0] digit_val_r;
    logic [2*NUM_DIGITS-1:0] digit_kind_r;
    logic                    update_r;
    logic [2:0]              update_idx_r;
    logic                    anode_err_r;

    logic [3:0]              zero_cnt_s;
    logic [2:0]              pos_s;
    logic                    pos_valid_s;
    logic                    multi_low_s;
    logic                    same_pair_s;
    logic                    commit_s;
    digit_t                  lut_s;
    digit_t                  stored_s;

    sseg_pattern_lut u_lut (
        .pattern (pat_r),
        .digit   (lut_s)
    );

    // Input sampling; idle bus is all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segs_r <= 7'h7F;
            an_r   <= '1;
        end else begin
            segs_r <= segs;
            an_r   <= an;
        end
    end

    // Count low anode bits and locate the selected position
    always_comb begin
        zero_cnt_s = 4'd0;
        pos_s      = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            zero_cnt_s = zero_cnt_s + {3'b000, ~an_r[i]};
            if (!an_r[i]) begin
                pos_s = 3'(i);
            end else begin
                pos_s = pos_s;
            end
        end
        pos_valid_s = (zero_cnt_s == 4'd1);
        multi_low_s = (zero_cnt_s > 4'd1);
    end

    // Fetch the digit currently stored at the tracked position
    always_comb begin
        stored_s = '{kind: KIND_BLANK, value: 4'h0};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (pos_r == 3'(i)) begin
                stored_s = '{kind: digit_kind_r[2*i +: 2], value: digit_val_r[4*i +: 4]};
            end else begin
                stored_s = stored_s;
            end
        end
    end

    assign same_pair_s = (pos_s == pos_r) && (segs_r == pat_r);
    // The sample that brings the count to STABLE_CYCLES is the commit point
    assign commit_s    = pos_valid_s && (state_r == ST_SETTLE) && same_pair_s &&
                         (cnt_r == CNT_W'(STABLE_CYCLES - 1));

    // Stability FSM and saturating sample counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            pos_r   <= 3'd0;
            pat_r   <= 7'h7F;
        end else if (!pos_valid_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else if ((state_r == ST_IDLE) || !same_pair_s) begin
            state_r <= ST_SETTLE;
            cnt_r   <= CNT_W'(1);
            pos_r   <= pos_s;
            pat_r   <= segs_r;
        end else if (state_r == ST_SETTLE) begin
            if (commit_s) begin
                state_r <= ST_HELD;
                cnt_r   <= CNT_W'(STABLE_CYCLES);
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1);
            end
        end else if (state_r == ST_HELD) begin
            state_r <= ST_HELD;
        end else begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end
    end

    // Committed digit storage plus update/anode_err pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_val_r  <= '0;
            digit_kind_r <= '0;
            update_r     <= 1'b0;
            update_idx_r <= 3'd0;
            anode_err_r  <= 1'b0;
        end else begin
            anode_err_r <= multi_low_s;
            update_r    <= 1'b0;
            if (commit_s && (lut_s != stored_s)) begin
                update_r     <= 1'b1;
                update_idx_r <= pos_r;
            end else begin
                update_idx_r <= update_idx_r;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (commit_s && (pos_r == 3'(i))) begin
                    digit_val_r[4*i +: 4]  <= lut_s.value;
                    digit_kind_r[2*i +: 2] <= lut_s.kind;
                end
            end
        end
    end

    assign digit_val  = digit_val_r;
    assign digit_kind = digit_kind_r;
    assign update     = update_r;
    assign update_idx = update_idx_r;
    assign anode_err  = anode_err_r;

endmodule

// File: tb/tb_sseg_decoder.sv
// Directed-vector bench for sseg_decoder with hand-computed expectations.
module tb_sseg_decoder;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [6:0]     segs;
    logic [N-1:0]   an;
    logic [4*N-1:0] digit_val;
    logic [2*N-1:0] digit_kind;
    logic           update;
    logic [2:0]     update_idx;
    logic           anode_err;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int upd_total = 0;
    int aerr_total = 0;
    int last_upd_cyc = -1;
    logic [2:0] last_idx = 3'd0;

    int u0, a0, c0;
    logic [6:0] scan_pat [4];
    int         scan_delta [4];
    int         scan_idx [4];

    sseg_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .segs       (segs),
        .an         (an),
        .digit_val  (digit_val),
        .digit_kind (digit_kind),
        .update     (update),
        .update_idx (update_idx),
        .anode_err  (anode_err)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping sampled on the falling edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (update === 1'b1) begin
            upd_total    = upd_total + 1;
            last_upd_cyc = cyc;
            last_idx     = update_idx;
        end
        if (anode_err === 1'b1) begin
            aerr_total = aerr_total + 1;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt = vec_cnt + 1;
        if (obs !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        scan_pat[0] = 7'b0001110; scan_delta[0] = 1; scan_idx[0] = 0;
        scan_pat[1] = 7'b0111111; scan_delta[1] = 1; scan_idx[1] = 1;
        scan_pat[2] = 7'b1111111; scan_delta[2] = 0; scan_idx[2] = 1;
        scan_pat[3] = 7'b1010101; scan_delta[3] = 1; scan_idx[3] = 3;

        // Reset with a noisy bus
        rst_n = 1'b0;
        segs  = 7'h7F;
        an    = '1;
        for (int i = 0; i < 4; i++) begin
            segs = 7'($urandom);
            an   = N'($urandom);
            step(1);
            check_vec("rst_kind", 32'(digit_kind), 32'd0);
            check_vec("rst_val", 32'(digit_val), 32'd0);
            check_vec("rst_update", 32'(update), 32'd0);
        end
        check_vec("rst_idx", 32'(update_idx), 32'd0);
        check_vec("rst_aerr", 32'(anode_err), 32'd0);

        segs  = 7'h7F;
        an    = '1;
        rst_n = 1'b1;
        u0 = upd_total;
        a0 = aerr_total;
        step(50);
        check_vec("idle_no_update", 32'(upd_total - u0), 32'd0);
        check_vec("idle_no_aerr", 32'(aerr_total - a0), 32'd0);

        // Basic commit of '2' at position 0
        u0 = upd_total;
        c0 = cyc;
        segs = 7'b0100100;
        an   = 4'b1110;
        step(16);
        check_vec("basic_early", 32'(upd_total - u0), 32'd0);
        check_vec("basic_val_pre", 32'(digit_val), 32'd0);
        step(1);
        check_vec("basic_update", 32'(update), 32'd1);
        check_vec("basic_idx", 32'(update_idx), 32'd0);
        check_vec("basic_latency", 32'(last_upd_cyc - c0), 32'd17);
        check_vec("basic_val", 32'(digit_val), 32'h0002);
        check_vec("basic_kind", 32'(digit_kind), 32'h01);
        step(1);
        check_vec("basic_pulse_len", 32'(update), 32'd0);
        step(100);
        check_vec("basic_held", 32'(upd_total - u0), 32'd1);

        // Glitch: a short '8' is replaced by a stable '9'
        u0 = upd_total;
        an   = 4'b1101;
        segs = 7'b0000000;
        step(10);
        segs = 7'b0011000;
        step(20);
        check_vec("glitch_pulses", 32'(upd_total - u0), 32'd1);
        check_vec("glitch_idx", 32'(last_idx), 32'd1);
        check_vec("glitch_val", 32'(digit_val), 32'h0092);
        check_vec("glitch_kind", 32'(digit_kind), 32'h05);

        // Full scan: F, neg, blank, invalid
        for (int p = 0; p < 4; p++) begin
            u0   = upd_total;
            an   = 4'b1111 ^ (4'b0001 << p);
            segs = scan_pat[p];
            step(20);
            check_vec("scan_pulses", 32'(upd_total - u0), 32'(scan_delta[p]));
            check_vec("scan_idx", 32'(last_idx), 32'(scan_idx[p]));
        end
        check_vec("scan_val", 32'(digit_val), 32'h000F);
        check_vec("scan_kind", 32'(digit_kind), 32'hC9);

        // Anode error interrupts a settling '5' at position 0
        u0 = upd_total;
        a0 = aerr_total;
        an   = 4'b1110;
        segs = 7'b0010010;
        step(8);
        an = 4'b1100;
        step(3);
        check_vec("aerr_val_hold", 32'(digit_val), 32'h000F);
        an = 4'b1110;
        c0 = cyc;
        step(16);
        check_vec("aerr_count", 32'(aerr_total - a0), 32'd3);
        check_vec("aerr_no_early", 32'(upd_total - u0), 32'd0);
        check_vec("aerr_kind_hold", 32'(digit_kind), 32'hC9);
        step(1);
        check_vec("aerr_update", 32'(update), 32'd1);
        check_vec("aerr_latency", 32'(last_upd_cyc - c0), 32'd17);
        check_vec("aerr_val", 32'(digit_val), 32'h0005);

        // Asynchronous reset at count 10 of a settling '3' at position 1
        an   = 4'b1101;
        segs = 7'b0110000;
        step(11);
        rst_n = 1'b0;
        #1;
        check_vec("arst_val", 32'(digit_val), 32'd0);
        check_vec("arst_kind", 32'(digit_kind), 32'd0);
        check_vec("arst_update", 32'(update), 32'd0);
        step(1);
        rst_n = 1'b1;
        u0 = upd_total;
        c0 = cyc;
        step(16);
        check_vec("arst_no_early", 32'(upd_total - u0), 32'd0);
        step(1);
        check_vec("arst_update_after", 32'(update), 32'd1);
        check_vec("arst_latency", 32'(last_upd_cyc - c0), 32'd17);
        check_vec("arst_idx", 32'(update_idx), 32'd1);
        check_vec("arst_val_after", 32'(digit_val), 32'h0030);
        check_vec("arst_kind_after", 32'(digit_kind), 32'h04);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
